regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised register file that replaces the fixed 16×32 register array in the datapath. It holds the program counter in register 0, provides four combinational read ports and two write ports, and tracks outstanding memory loads with a per-register busy scoreboard. It sits between the decoder/controller (addresses, enables, stall) and the ALU and load/store unit (data), and raises `hazard` so the controller can hold an instruction.

## Interface
- `WIDTH`, 32, data width of every register and of the PC.
- `NREGS`, 16, register count; power of two, at least 4. `AW = $clog2(NREGS)` is derived.
- `PC_STEP`, 1, amount added to the PC on `pc_inc`.
- `RESET_PC`, 0, PC value after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rd_en`  in  4  per-port read-valid flags; used only for hazard detection.
- `rd_addr_a`, `rd_addr_b`, `rd_addr_c`, `rd_addr_d`  in  AW each  read addresses.
- `rd_data_a`, `rd_data_b`, `rd_data_c`, `rd_data_d`  out  WIDTH each  combinational read data.
- `w1_en`, `w2_en`  in  1  write enables.
- `w1_addr`, `w2_addr`  in  AW  write addresses.
- `w1_data`, `w2_data`  in  WIDTH  write data.
- `pc_inc`  in  1  advance the PC this cycle.
- `stall`  in  1  external stall; suppresses all architectural updates except load returns.
- `ld_issue`  in  1  a load to `ld_dest` is leaving for memory.
- `ld_dest`  in  AW  load destination register.
- `ld_done`  in  1  load data is returning this cycle.
- `ld_done_dest`  in  AW  destination of the returning load.
- `ld_data`  in  WIDTH  returned load data.
- `program_counter`  out  WIDTH  register 0.
- `busy`  out  NREGS  scoreboard; bit *i* = load outstanding to register *i*.
- `hazard`  out  1  combinational; the current request touches a busy register.
- `ld_err`  out  1  sticky; a load returned to a non-busy register.

## Operation
- **Reads.** Port *x* returns `regs[rd_addr_x]`. Register 0 reads the PC. There is no write-to-read bypass: a write becomes visible the cycle after its clock edge.
- **Hazard detection.** `hazard` = 1 when any of the following targets a register whose `busy` bit is set:
  - an enabled read port address;
  - an enabled `w1`/`w2` address;
  - `ld_dest` with `ld_issue` = 1;
  - the PC (busy[0] = 1) with `pc_inc` = 1.
- **Update gating.**
  - `hold = stall | hazard`.
  - When `hold` = 1: no `w1`/`w2` write, no PC increment, and no busy-set takes effect.
  - `ld_done` is never held.
- **Write priority.**
  - If both write ports target the same address, `w2` wins.
  - An explicit write to register 0 (branch) overrides `pc_inc`.
  - Otherwise `pc_inc` sets PC = PC + `PC_STEP` mod 2^WIDTH, with silent wrap-around.
- **Scoreboard.**
  - An un-held `ld_issue` sets `busy[ld_dest]`.
  - `ld_done` with `busy[ld_done_dest]` = 1 writes `ld_data` into that register and clears its busy bit.
  - `ld_done` with `busy[ld_done_dest]` = 0 writes nothing and sets `ld_err`.
  - `ld_done` and an un-held `ld_issue` to the same register in one cycle: the data is written and busy stays 1 (clear, then set).
  - `ld_done` cannot collide with `w1`/`w2` on the same address, because that write raises `hazard` and is dropped.
  - Multiple loads may be outstanding, at most one per register.
- **Reset.** All registers = 0, PC = `RESET_PC`, `busy` = 0, `ld_err` = 0. Reset is asynchronous and takes effect immediately. Reset during outstanding loads discards them; a later `ld_done` to a now non-busy register sets `ld_err`.

## Timing
- Read latency: 0 cycles (combinational).
- Write and PC update latency: 1 edge.
- `busy` changes on the edge after `ld_issue` / `ld_done`.
- `hazard` is combinational from the addresses, enables and `busy`. The controller must hold its request stable while `hazard` = 1; the block applies the hold itself.
- The earliest a dependent read clears the hazard is the cycle after `ld_done`, and it then reads `ld_data`.
- `ld_err` stays set until reset.

## Test plan
- **Reset and PC counting:** `reset` pulse, then `pc_inc` = 1 for 3 cycles with `RESET_PC` = 0x100 → `program_counter` = 0x100, 0x101, 0x102, 0x103; all reads = 0; `busy` = 0.
- **Branch and collision:** `w1` (addr 0, 0x40) with `pc_inc` = 1 → PC = 0x40. `w1` (r5, 0xAA) and `w2` (r5, 0xBB) in the same cycle → r5 = 0xBB.
- **Load scoreboard:** `ld_issue` to r3; next cycle read r3 with `rd_en` → `hazard` = 1, and a concurrent `w1` to r7 is not written. Two cycles later `ld_done` to r3 with 0xDEAD → busy[3] = 0 and r3 = 0xDEAD on the following cycle; the retried `w1` to r7 succeeds.
- **Stall vs. return:** `stall` = 1 with `pc_inc`, `w1` to r2, and `ld_done` to busy r4 → PC and r2 unchanged; r4 written; busy[4] = 0.
- **Errors and wrap:** `ld_done` to r6 with busy[6] = 0 → `ld_err` = 1, r6 unchanged. PC = 0xFFFFFFFF with `pc_inc` → PC = 0.
- **Reset mid-load:** `ld_issue` to r9, assert `reset` asynchronously (mid-cycle) → `busy` = 0 immediately. A subsequent `ld_done` to r9 → `ld_err` = 1, r9 = 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: PC-in-r0 register file, 4 read / 2 write ports, load busy scoreboard with hazard detect.
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter logic [WIDTH-1:0] PC_STEP = 1,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       rd_en,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic [AW-1:0]    rd_addr_c,
  input  logic [AW-1:0]    rd_addr_d,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic [WIDTH-1:0] rd_data_c,
  output logic [WIDTH-1:0] rd_data_d,
  input  logic             w1_en,
  input  logic             w2_en,
  input  logic [AW-1:0]    w1_addr,
  input  logic [AW-1:0]    w2_addr,
  input  logic [WIDTH-1:0] w1_data,
  input  logic [WIDTH-1:0] w2_data,
  input  logic             pc_inc,
  input  logic             stall,
  input  logic             ld_issue,
  input  logic [AW-1:0]    ld_dest,
  input  logic             ld_done,
  input  logic [AW-1:0]    ld_done_dest,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] program_counter,
  output logic [NREGS-1:0] busy,
  output logic             hazard,
  output logic             ld_err
);
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             ld_err_q, ld_err_d;
  logic [AW-1:0]    rd_addr [4];
  logic             rd_hz, hold, ld_ok;

  assign rd_addr = '{rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d};
  assign rd_data_a = regs_q[rd_addr_a];
  assign rd_data_b = regs_q[rd_addr_b];
  assign rd_data_c = regs_q[rd_addr_c];
  assign rd_data_d = regs_q[rd_addr_d];
  assign program_counter = regs_q[0];
  assign busy = busy_q;
  assign ld_err = ld_err_q;

  always_comb begin
    rd_hz = 1'b0;
    for (int i = 0; i < 4; i++) rd_hz = rd_hz | (rd_en[i] & busy_q[rd_addr[i]]);
  end

  assign hazard = rd_hz | (w1_en & busy_q[w1_addr]) | (w2_en & busy_q[w2_addr])
                | (ld_issue & busy_q[ld_dest]) | (pc_inc & busy_q[0]);
  assign hold = stall | hazard;
  assign ld_ok = ld_done & busy_q[ld_done_dest];

  // later assignments win: pc_inc < w1 < w2; load returns land regardless of hold
  always_comb begin
    regs_d = regs_q;
    if (!hold && pc_inc) regs_d[0] = regs_q[0] + PC_STEP;
    if (!hold && w1_en) regs_d[w1_addr] = w1_data;
    if (!hold && w2_en) regs_d[w2_addr] = w2_data;
    if (ld_ok) regs_d[ld_done_dest] = ld_data;
    busy_d = busy_q;
    if (ld_ok) busy_d[ld_done_dest] = 1'b0;
    if (!hold && ld_issue) busy_d[ld_dest] = 1'b1;
    ld_err_d = ld_err_q | (ld_done & ~busy_q[ld_done_dest]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == 0) ? RESET_PC : '0;
      busy_q   <= '0;
      ld_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      busy_q   <= busy_d;
      ld_err_q <= ld_err_d;
    end
  end
endmodule
